seven_seg_mux_wrapper: RTL and testbench

Wishbone-controlled, parametrised multi-digit seven-segment controller for the Caravel user project area. It generalises the single-digit seconds display to N time-multiplexed digits with a BCD counter, a hex direct-drive mode, programmable scan rate and output polarity. It sits between the Wishbone slave port and the `io_*` pads and owns the pad mux for its project.

---
 rtl/seven_seg_pkg.sv | 25 ++
 rtl/seven_seg_decoder.sv | 32 +++
 rtl/seven_seg_mux_wrapper.sv | 190 +++++++++++++++++++
 tb/tb_seven_seg_mux_wrapper.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment display blocks: register map,
// CTRL bit positions, reset values and the segment vector type.
package seven_seg_pkg;

    localparam logic [31:0] OFF_CTRL     = 32'h00;
    localparam logic [31:0] OFF_COMPARE  = 32'h04;
    localparam logic [31:0] OFF_SCAN_DIV = 32'h08;
    localparam logic [31:0] OFF_DIRECT   = 32'h0C;
    localparam logic [31:0] OFF_COUNT    = 32'h10;

    localparam int CTRL_ACTIVE   = 0;
    localparam int CTRL_SOFT_RST = 1;
    localparam int CTRL_RUN      = 2;
    localparam int CTRL_MODE     = 3;

    localparam logic [3:0]  CTRL_RST     = 4'b0010;
    localparam logic [23:0] COMPARE_RST  = 24'd9_999_999;
    localparam logic [15:0] SCAN_DIV_RST = 16'd999;

    // Segment order: bit0 = a ... bit6 = g
    typedef logic [6:0] seg_t;

    typedef enum logic {BUS_IDLE, BUS_ACK} bus_state_t;

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational hex nibble to active-high seven-segment pattern (a = bit0).
module seven_seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    always_comb begin
        seg = '0;
        case (nibble)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = '0;
        endcase
    end

endmodule

// File: rtl/seven_seg_mux_wrapper.sv
// Wishbone-controlled N-digit multiplexed seven-segment controller: register
// file, BCD counter, digit scanner and ownership of the project pad mux.
module seven_seg_mux_wrapper
    import seven_seg_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE      = 32'h3000_0000,
    parameter int          N_DIGITS       = 4,
    parameter int          SEG_PIN        = 8,
    parameter int          DIG_PIN        = 15,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          DIG_ACTIVE_LOW = 1'b0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic [37:0] io_in,
    output logic [37:0] io_out,
    output logic [37:0] io_oeb
);

    localparam int CW = 4 * N_DIGITS;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [1:0]          rst_sync;
    logic                rst_n;
    bus_state_t          state;
    logic [3:0]          ctrl;
    logic [23:0]         compare, compare_wr, tick;
    logic [15:0]         scan_div, scan_wr, dwell;
    logic [CW-1:0]       direct, direct_wr, count, count_wr;
    logic [IW-1:0]       idx;
    logic [31:0]         off, rd_data;
    logic                valid, wr_en, soft_rst, run, inc;
    logic                hit_ctrl, hit_compare, hit_scan, hit_direct, hit_count;
    logic [3:0]          nibble;
    seg_t                seg_raw, seg_q;
    logic [N_DIGITS-1:0] dig_q;
    logic                unused;

    // Assert asynchronously, release two clocks after the pin goes high
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) rst_sync <= '0;
        else             rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign off         = wbs_adr_i - ADDR_BASE;
    assign hit_ctrl    = (off == OFF_CTRL);
    assign hit_compare = (off == OFF_COMPARE);
    assign hit_scan    = (off == OFF_SCAN_DIV);
    assign hit_direct  = (off == OFF_DIRECT);
    assign hit_count   = (off == OFF_COUNT);
    assign valid       = wbs_cyc_i & wbs_stb_i;
    assign wr_en       = valid & wbs_we_i & (state == BUS_IDLE);
    assign wbs_ack_o   = (state == BUS_ACK);
    assign soft_rst    = ctrl[CTRL_SOFT_RST];
    assign run         = ctrl[CTRL_RUN];
    assign inc         = run & ~soft_rst & (tick == compare);
    assign unused      = ^{io_in, wbs_dat_i[31:24], wbs_sel_i[3]};

    always_comb begin
        rd_data = '0;
        if (hit_ctrl)        rd_data[3:0]    = ctrl;
        else if (hit_compare) rd_data[23:0]  = compare;
        else if (hit_scan)   rd_data[15:0]   = scan_div;
        else if (hit_direct) rd_data[CW-1:0] = direct;
        else if (hit_count)  rd_data[CW-1:0] = count;
    end

    // Byte-lane merge; COUNT nibbles above 9 are clamped to 9 on the way in
    always_comb begin
        compare_wr = compare;
        scan_wr    = scan_div;
        direct_wr  = direct;
        count_wr   = count;
        for (int b = 0; b < 3; b++)
            if (wbs_sel_i[b]) compare_wr[8*b +: 8] = wbs_dat_i[8*b +: 8];
        for (int b = 0; b < 2; b++)
            if (wbs_sel_i[b]) scan_wr[8*b +: 8] = wbs_dat_i[8*b +: 8];
        for (int k = 0; k < N_DIGITS; k++) begin
            if (wbs_sel_i[k/2]) begin
                direct_wr[4*k +: 4] = wbs_dat_i[4*k +: 4];
                count_wr[4*k +: 4]  = (wbs_dat_i[4*k +: 4] > 4'd9) ? 4'd9 : wbs_dat_i[4*k +: 4];
            end
        end
    end

    function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
        logic carry;
        bcd_inc = v;
        carry   = 1'b1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (carry) begin
                if (v[4*k +: 4] == 4'd9) bcd_inc[4*k +: 4] = 4'd0;
                else begin
                    bcd_inc[4*k +: 4] = v[4*k +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    endfunction

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BUS_IDLE;
            wbs_dat_o <= '0;
        end else begin
            case (state)
                BUS_IDLE: if (valid) begin
                    state     <= BUS_ACK;
                    wbs_dat_o <= wbs_we_i ? 32'h0 : rd_data;
                end
                BUS_ACK: begin
                    state     <= BUS_IDLE;
                    wbs_dat_o <= '0;
                end
                default: state <= BUS_IDLE;
            endcase
        end
    end

    assign nibble = ctrl[CTRL_MODE] ? direct[4*idx +: 4] : count[4*idx +: 4];

    seven_seg_decoder u_dec (.nibble(nibble), .seg(seg_raw));

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ctrl     <= CTRL_RST;
            compare  <= COMPARE_RST;
            scan_div <= SCAN_DIV_RST;
            direct   <= '0;
            count    <= '0;
            tick     <= '0;
            dwell    <= '0;
            idx      <= '0;
            seg_q    <= {7{SEG_ACTIVE_LOW}};
            dig_q    <= {N_DIGITS{DIG_ACTIVE_LOW}};
        end else begin
            if (wr_en && hit_ctrl && wbs_sel_i[0]) ctrl <= wbs_dat_i[3:0];
            if (wr_en && hit_compare) compare  <= compare_wr;
            if (wr_en && hit_scan)    scan_div <= scan_wr;
            if (wr_en && hit_direct)  direct   <= direct_wr;

            if (soft_rst || (wr_en && hit_compare)) tick <= '0;
            else if (run) tick <= (tick == compare) ? 24'd0 : tick + 24'd1;

            if (soft_rst)                  count <= '0;
            else if (wr_en && hit_count)   count <= count_wr;
            else if (inc)                  count <= bcd_inc(count);

            // >= so a SCAN_DIV shrink below the live dwell count recovers at once
            if (soft_rst) begin
                dwell <= '0;
                idx   <= '0;
            end else if (dwell >= scan_div) begin
                dwell <= '0;
                idx   <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + IW'(1);
            end else begin
                dwell <= dwell + 16'd1;
            end

            seg_q <= seg_raw ^ {7{SEG_ACTIVE_LOW}};
            dig_q <= (soft_rst ? '0 : (N_DIGITS'(1) << idx)) ^ {N_DIGITS{DIG_ACTIVE_LOW}};
        end
    end

    always_comb begin
        io_out = '0;
        io_oeb = '0;
        if (ctrl[CTRL_ACTIVE]) begin
            io_oeb = '1;
            for (int k = 0; k < 7; k++) begin
                io_out[SEG_PIN+k] = seg_q[k];
                io_oeb[SEG_PIN+k] = 1'b0;
            end
            for (int k = 0; k < N_DIGITS; k++) begin
                io_out[DIG_PIN+k] = dig_q[k];
                io_oeb[DIG_PIN+k] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_mux_wrapper.sv
// Directed bench for seven_seg_mux_wrapper: bus reads go through a scoreboard
// queue checked by an independent ack monitor; pad behaviour is sampled directly.
module tb_seven_seg_mux_wrapper;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, dat = '0;
    logic        ack;
    logic [31:0] rdat;
    logic [37:0] io_in = '0;
    logic [37:0] io_out, io_oeb;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    logic        prev_ack = 1'b0;
    logic        mon_en = 1'b0;
    logic [37:0] exp_oeb;
    int          idxs[20];
    int          zeros, s;
    logic [6:0]  hex_exp[4];

    always #5 clk = ~clk;

    seven_seg_mux_wrapper #(
        .ADDR_BASE(BASE), .N_DIGITS(4), .SEG_PIN(8), .DIG_PIN(15),
        .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b1)
    ) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every ack pops one expected read word
    always @(negedge clk) begin
        if (mon_en) begin
            if (ack) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack: got ack with dat %0h, expected no ack", rdat);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (rdat !== mon_exp) begin
                        errors++;
                        $display("FAIL read_data: got %0h, expected %0h", rdat, mon_exp);
                    end
                end
                if (prev_ack) check("ack_width", 2, 1);
            end else begin
                check("dat_idle", rdat, 0);
            end
        end
        prev_ack = ack;
    end

    task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s_in, input logic [31:0] exp_rd);
        int n;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s_in;
        exp_q.push_back(w ? 32'h0 : exp_rd);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 8);
        check("ack_latency", n, 1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        wb(1'b1, BASE + off, d, 4'hF, 32'h0);
    endtask

    task automatic rd(input logic [31:0] off, input logic [31:0] e);
        wb(1'b0, BASE + off, 32'h0, 4'hF, e);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running after %0d checks, expected finish", checks);
        $fatal(1);
    end

    initial begin
        hex_exp[0] = 7'h71; hex_exp[1] = 7'h4F; hex_exp[2] = 7'h77; hex_exp[3] = 7'h3F;
        exp_oeb = '1;
        exp_oeb[18:8] = '0;

        // Bring the synchroniser up, then assert reset for a real falling edge
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        mon_en = 1'b1;
        check("rst_io_out", io_out, 0);
        check("rst_io_oeb", io_oeb, 0);
        check("rst_ack", ack, 0);
        check("rst_dat", rdat, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        rd(32'h00, 32'h2);
        rd(32'h20, 32'h0);
        wb(1'b1, BASE + 32'h20, 32'hFFFF_FFFF, 4'hF, 32'h0);
        rd(32'h20, 32'h0);
        rd(32'h04, 32'h0098_967F);
        rd(32'h08, 32'h0000_03E7);

        // Counter period: COMPARE=3 -> increments every 4 cycles
        wr(32'h08, 32'h1);
        wr(32'h04, 32'h3);
        wr(32'h00, 32'h5);
        repeat (12) @(negedge clk);
        wr(32'h00, 32'h1);
        rd(32'h10, 32'h0003);

        // Wrap 9999 -> 0000
        wr(32'h10, 32'h9999);
        rd(32'h10, 32'h9999);
        wr(32'h04, 32'h3);
        wr(32'h00, 32'h5);
        repeat (4) @(negedge clk);
        wr(32'h00, 32'h1);
        rd(32'h10, 32'h0000);

        // Clamp and byte selects
        wr(32'h10, 32'h00F0);
        rd(32'h10, 32'h0090);
        wb(1'b1, BASE + 32'h10, 32'h0000_7777, 4'b0001, 32'h0);
        rd(32'h10, 32'h0077);

        // COMPARE=0: write collides with an increment, then two more increments
        wr(32'h04, 32'h0);
        wr(32'h00, 32'h5);
        wr(32'h10, 32'h1298);
        wr(32'h00, 32'h1);
        rd(32'h10, 32'h1300);
        rd(32'h04, 32'h0);

        // Scan rotation with SCAN_DIV=1, digit selects active low
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            zeros = 0;
            idxs[i] = -1;
            for (int j = 0; j < 4; j++)
                if (!io_out[15+j]) begin
                    zeros++;
                    idxs[i] = j;
                end
            check("one_digit", zeros, 1);
        end
        check("pad_oeb", io_oeb, exp_oeb);
        check("pad_unused_out", io_out & exp_oeb, 0);
        s = -1;
        for (int i = 1; i < 20; i++)
            if (s < 0 && idxs[i] != idxs[i-1]) s = i;
        check("scan_started", (s > 0), 1);
        if (s > 0)
            for (int i = s; i < 19; i++) begin
                if (((i - s) % 2) == 0) check("scan_dwell", idxs[i+1], idxs[i]);
                else check("scan_rotate", idxs[i+1], (idxs[i] + 1) % 4);
            end

        // Hex mode from DIRECT
        wr(32'h0C, 32'h0A3F);
        rd(32'h0C, 32'h0A3F);
        wr(32'h00, 32'h9);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            for (int j = 0; j < 4; j++)
                if (!io_out[15+j]) check("hex_seg", io_out[14:8], hex_exp[j]);
        end

        // soft_rst: selects deasserted (all high), COUNT forced to 0
        wr(32'h00, 32'h3);
        repeat (2) @(negedge clk);
        check("softrst_dig", io_out[18:15], 4'hF);
        rd(32'h10, 32'h0);
        rd(32'h00, 32'h3);

        // Async reset mid-scan
        wr(32'h00, 32'h1);
        repeat (3) @(negedge clk);
        check("active_oeb", io_oeb, exp_oeb);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_io_out", io_out, 0);
        check("async_io_oeb", io_oeb, 0);
        check("async_ack", ack, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        rd(32'h00, 32'h2);
        rd(32'h08, 32'h3E7);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
